// File: rtl/mem_dma_pkg.sv
// Shared types and constants for the memory-to-memory word copy engine.
package mem_dma_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      READ   = 2'd1,
      WRITE  = 2'd2,
      FINISH = 2'd3
   } state_e;

   localparam int unsigned WORD_BYTES = 2;
   localparam int unsigned CNT_W      = 16;
   localparam logic [1:0]  BE_FULL    = 2'b11;
   localparam logic [1:0]  BE_NONE    = 2'b00;

endpackage

// File: rtl/mem_dma_watchdog.sv
// Response watchdog: counts cycles of an outstanding request and flags expiry
// after LIMIT cycles. Only instantiated when MEM_DMA_TIMEOUT_EN is defined.
module mem_dma_watchdog #(
   parameter int unsigned LIMIT = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic clear_i,
   input  logic run_i,
   output logic expired_o
);

   localparam int unsigned CNT_W = $clog2(LIMIT + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             expired_q, expired_d;

   // Saturating count; the flag rises in the LIMIT-th outstanding cycle.
   always_comb begin
      cnt_d     = cnt_q;
      expired_d = 1'b0;
      if (clear_i) begin
         cnt_d = '0;
      end else if (run_i) begin
         if (cnt_q != CNT_W'(LIMIT - 1)) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
         expired_d = (cnt_d == CNT_W'(LIMIT - 1));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q     <= '0;
         expired_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         expired_q <= expired_d;
      end
   end

   assign expired_o = expired_q;

endmodule

// File: rtl/mem_dma_copy.sv
// Word-by-word block copy engine driving the 16-bit memory responder port.
// Optional response watchdog enabled by defining MEM_DMA_TIMEOUT_EN.
module mem_dma_copy
   import mem_dma_pkg::*;
#(
   parameter int unsigned ADDR_W         = 16,
   parameter int unsigned DATA_W         = 16,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] src_addr,
   input  logic [ADDR_W-1:0] dst_addr,
   input  logic [CNT_W-1:0]  word_count,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic              mem_read,
   output logic              mem_write,
   output logic [1:0]        mem_byte_enable,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_resp,
   input  logic [DATA_W-1:0] mem_rdata
);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] src_q, src_d;
   logic [ADDR_W-1:0] dst_q, dst_d;
   logic [CNT_W-1:0]  remaining_q, remaining_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              error_q, error_d;
   logic              aborted_q, aborted_d;
   logic              rd_q, rd_d;
   logic              wr_q, wr_d;
   logic [1:0]        be_q, be_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              expired;
   logic              unused_addr_lsb;

   // Byte addresses are word-aligned on capture, so bit 0 never matters.
   assign unused_addr_lsb = src_addr[0] ^ dst_addr[0];

`ifdef MEM_DMA_TIMEOUT_EN
   logic wd_clear, wd_run;

   assign wd_clear = (state_d != state_q) && ((state_d == READ) || (state_d == WRITE));
   assign wd_run   = ((state_q == READ) || (state_q == WRITE)) && !mem_resp;

   mem_dma_watchdog #(
      .LIMIT     (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk       (clk),
      .rst       (rst),
      .clear_i   (wd_clear),
      .run_i     (wd_run),
      .expired_o (expired)
   );
`else
   localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
   assign expired = 1'b0;
`endif

   // Next-state and registered-output logic; mem_wdata doubles as the word buffer.
   always_comb begin
      state_d     = state_q;
      src_d       = src_q;
      dst_d       = dst_q;
      remaining_d = remaining_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      error_d     = 1'b0;
      aborted_d   = aborted_q;
      rd_d        = rd_q;
      wr_d        = wr_q;
      be_d        = be_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               src_d       = {src_addr[ADDR_W-1:1], 1'b0};
               dst_d       = {dst_addr[ADDR_W-1:1], 1'b0};
               remaining_d = word_count;
               busy_d      = 1'b1;
               aborted_d   = 1'b0;
               if (word_count == '0) begin
                  state_d = FINISH;
               end else begin
                  state_d = READ;
                  rd_d    = 1'b1;
                  addr_d  = {src_addr[ADDR_W-1:1], 1'b0};
               end
            end
         end

         READ: begin
            if (mem_resp) begin
               rd_d    = 1'b0;
               wr_d    = 1'b1;
               be_d    = BE_FULL;
               addr_d  = dst_q;
               wdata_d = mem_rdata;
               state_d = WRITE;
            end else if (expired) begin
               rd_d      = 1'b0;
               aborted_d = 1'b1;
               state_d   = FINISH;
            end
         end

         WRITE: begin
            if (mem_resp) begin
               wr_d        = 1'b0;
               be_d        = BE_NONE;
               src_d       = src_q + ADDR_W'(WORD_BYTES);
               dst_d       = dst_q + ADDR_W'(WORD_BYTES);
               remaining_d = remaining_q - CNT_W'(1);
               if (remaining_q == CNT_W'(1)) begin
                  state_d = FINISH;
               end else begin
                  state_d = READ;
                  rd_d    = 1'b1;
                  addr_d  = src_q + ADDR_W'(WORD_BYTES);
               end
            end else if (expired) begin
               wr_d      = 1'b0;
               be_d      = BE_NONE;
               aborted_d = 1'b1;
               state_d   = FINISH;
            end
         end

         FINISH: begin
            done_d  = 1'b1;
            error_d = aborted_q;
            busy_d  = 1'b0;
            state_d = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         src_q       <= '0;
         dst_q       <= '0;
         remaining_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
         aborted_q   <= 1'b0;
         rd_q        <= 1'b0;
         wr_q        <= 1'b0;
         be_q        <= BE_NONE;
         addr_q      <= '0;
         wdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         src_q       <= src_d;
         dst_q       <= dst_d;
         remaining_q <= remaining_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         error_q     <= error_d;
         aborted_q   <= aborted_d;
         rd_q        <= rd_d;
         wr_q        <= wr_d;
         be_q        <= be_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
      end
   end

   assign busy            = busy_q;
   assign done            = done_q;
   assign error           = error_q;
   assign mem_read        = rd_q;
   assign mem_write       = wr_q;
   assign mem_byte_enable = be_q;
   assign mem_address     = addr_q;
   assign mem_wdata       = wdata_q;

endmodule

// File: tb/tb_mem_dma_copy.sv
// Bench for mem_dma_copy: memory responder model, transaction scoreboard and
// table-driven copy vectors plus reset / timeout sequences.
module tb_mem_dma_copy;

   typedef struct {
      logic        wr;
      logic [15:0] addr;
      logic [15:0] data;
      logic [1:0]  be;
   } txn_t;

   typedef struct {
      logic [15:0] src;
      logic [15:0] dst;
      logic [15:0] cnt;
      int          lat;
      logic [15:0] base;
      logic [15:0] step;
      bit          poke;
      int          exp_done;
   } vec_t;

   logic        clk, rst, start;
   logic [15:0] src_addr, dst_addr, word_count;
   logic        busy, done, error;
   logic        mem_read, mem_write, mem_resp;
   logic [1:0]  mem_byte_enable;
   logic [15:0] mem_address, mem_wdata, mem_rdata;

   int n_chk  = 0;
   int n_fail = 0;

   logic [15:0] mem     [0:32767];
   logic [15:0] exp_mem [0:32767];
   txn_t        exp_q[$];
   txn_t        obs_q[$];
   txn_t        rsp_t;
   int          latency, lat_cnt, proto_err;
   bit          hold;
   logic        pl_en;
   logic [15:0] pl_addr, pl_data;
   logic [14:0] idx;
   logic        prev_rd, prev_wr, prev_resp;
   logic [15:0] prev_addr, prev_wdata;
   logic [1:0]  prev_be;

   mem_dma_copy #(
      .ADDR_W          (16),
      .DATA_W          (16),
      .TIMEOUT_CYCLES  (8)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .start           (start),
      .src_addr        (src_addr),
      .dst_addr        (dst_addr),
      .word_count      (word_count),
      .busy            (busy),
      .done            (done),
      .error           (error),
      .mem_read        (mem_read),
      .mem_write       (mem_write),
      .mem_byte_enable (mem_byte_enable),
      .mem_address     (mem_address),
      .mem_wdata       (mem_wdata),
      .mem_resp        (mem_resp),
      .mem_rdata       (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign idx = mem_address[15:1];

   // Responder: idle samples a request, waits `latency` cycles, responds one cycle.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_resp  <= 1'b0;
         mem_rdata <= '0;
         lat_cnt   <= 0;
      end else begin
         mem_resp <= 1'b0;
         if (pl_en) mem[pl_addr[15:1]] <= pl_data;
         if (mem_resp) begin
            lat_cnt <= 0;
         end else if ((mem_read || mem_write) && !hold) begin
            if (lat_cnt >= latency) begin
               lat_cnt  <= 0;
               mem_resp <= 1'b1;
               rsp_t.wr   = mem_write;
               rsp_t.addr = mem_address;
               rsp_t.be   = mem_byte_enable;
               if (mem_write) begin
                  if (mem_byte_enable[0]) mem[idx][7:0]  <= mem_wdata[7:0];
                  if (mem_byte_enable[1]) mem[idx][15:8] <= mem_wdata[15:8];
                  rsp_t.data = mem_wdata;
               end else begin
                  mem_rdata  <= mem[idx];
                  rsp_t.data = mem[idx];
               end
               obs_q.push_back(rsp_t);
            end else begin
               lat_cnt <= lat_cnt + 1;
            end
         end else begin
            lat_cnt <= 0;
         end
      end
   end

   // Protocol monitor: exclusive requests and stable payload until response.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_rd   <= 1'b0;
         prev_wr   <= 1'b0;
         prev_resp <= 1'b0;
      end else begin
         if (mem_read && mem_write) proto_err <= proto_err + 1;
         else if ((prev_rd || prev_wr) && !prev_resp && (mem_read || mem_write) &&
                  ({prev_rd, prev_wr, prev_addr, prev_wdata, prev_be} !==
                   {mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable}))
            proto_err <= proto_err + 1;
         prev_rd    <= mem_read;
         prev_wr    <= mem_write;
         prev_resp  <= mem_resp;
         prev_addr  <= mem_address;
         prev_wdata <= mem_wdata;
         prev_be    <= mem_byte_enable;
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic preload(input logic [15:0] a, input logic [15:0] d);
      @(negedge clk);
      pl_en   = 1'b1;
      pl_addr = a;
      pl_data = d;
      exp_mem[a[15:1]] = d;
      @(negedge clk);
      pl_en = 1'b0;
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, ".busy"},  64'(busy), 64'd0);
      check({tag, ".done"},  64'(done), 64'd0);
      check({tag, ".error"}, 64'(error), 64'd0);
      check({tag, ".rd"},    64'(mem_read), 64'd0);
      check({tag, ".wr"},    64'(mem_write), 64'd0);
      check({tag, ".be"},    64'(mem_byte_enable), 64'd0);
      check({tag, ".addr"},  64'(mem_address), 64'd0);
      check({tag, ".wdata"}, 64'(mem_wdata), 64'd0);
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      logic [15:0] s, d;
      txn_t        t;
      int          cyc;
      bit          busy_ok;
      latency = v.lat;
      s = {v.src[15:1], 1'b0};
      for (int i = 0; i < int'(v.cnt); i++) begin
         preload(s, 16'(v.base + 16'(i) * v.step));
         s = s + 16'd2;
      end
      // Reference model: ascending sequential copy, one read then one write per word.
      exp_q.delete();
      obs_q.delete();
      s = {v.src[15:1], 1'b0};
      d = {v.dst[15:1], 1'b0};
      for (int i = 0; i < int'(v.cnt); i++) begin
         t = '{wr: 1'b0, addr: s, data: exp_mem[s[15:1]], be: 2'b00};
         exp_q.push_back(t);
         exp_mem[d[15:1]] = t.data;
         t = '{wr: 1'b1, addr: d, data: t.data, be: 2'b11};
         exp_q.push_back(t);
         s = s + 16'd2;
         d = d + 16'd2;
      end
      @(negedge clk);
      start      = 1'b1;
      src_addr   = v.src;
      dst_addr   = v.dst;
      word_count = v.cnt;
      @(negedge clk);
      start   = 1'b0;
      cyc     = 1;
      busy_ok = 1'b1;
      while (!done && cyc < 2000) begin
         if (!busy) busy_ok = 1'b0;
         if (v.poke && cyc == 3) begin
            start      = 1'b1;
            src_addr   = 16'h7000;
            dst_addr   = 16'h7800;
            word_count = 16'd5;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      check({tag, ".done_cycle"}, 64'(cyc), 64'(v.exp_done));
      check({tag, ".busy_during"}, 64'(busy_ok), 64'd1);
      check({tag, ".busy_at_done"}, 64'(busy), 64'd0);
      check({tag, ".error"}, 64'(error), 64'd0);
      @(negedge clk);
      check({tag, ".done_pulse"}, 64'(done), 64'd0);
      check({tag, ".txn_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
         check($sformatf("%s.txn%0d", tag, i),
               {29'd0, obs_q[i].wr, obs_q[i].addr, obs_q[i].data, obs_q[i].be},
               {29'd0, exp_q[i].wr, exp_q[i].addr, exp_q[i].data, exp_q[i].be});
      d = {v.dst[15:1], 1'b0};
      for (int i = 0; i < int'(v.cnt); i++) begin
         check($sformatf("%s.mem%0d", tag, i), 64'(mem[d[15:1]]), 64'(exp_mem[d[15:1]]));
         d = d + 16'd2;
      end
   endtask

   vec_t vecs[6];
   int   cyc;
   int   rd_cyc;

   initial begin
      vecs[0] = '{src: 16'h0100, dst: 16'h0200, cnt: 16'd1, lat: 0, base: 16'hBEEF, step: 16'h0000, poke: 1'b0, exp_done: 6};
      vecs[1] = '{src: 16'h0010, dst: 16'h0800, cnt: 16'd4, lat: 1, base: 16'h1111, step: 16'h1111, poke: 1'b1, exp_done: 26};
      vecs[2] = '{src: 16'h0040, dst: 16'h0900, cnt: 16'd0, lat: 0, base: 16'h0000, step: 16'h0000, poke: 1'b0, exp_done: 2};
      vecs[3] = '{src: 16'hFFFF, dst: 16'h0003, cnt: 16'd2, lat: 0, base: 16'hA5A5, step: 16'h0101, poke: 1'b0, exp_done: 10};
      vecs[4] = '{src: 16'h0300, dst: 16'h0302, cnt: 16'd3, lat: 2, base: 16'hC001, step: 16'h0001, poke: 1'b0, exp_done: 26};
      vecs[5] = '{src: 16'h1001, dst: 16'h2001, cnt: 16'd2, lat: 3, base: 16'h5A00, step: 16'h0011, poke: 1'b0, exp_done: 22};

      rst = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; word_count = '0;
      hold = 1'b0; latency = 0; pl_en = 1'b0; pl_addr = '0; pl_data = '0; proto_err = 0;
      #1 rst = 1'b1;
      #2 check_outputs_zero("reset");
      repeat (3) @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // Asynchronous reset while a write is outstanding.
      latency = 5;
      preload(16'h4000, 16'h1234);
      @(negedge clk);
      start = 1'b1; src_addr = 16'h4000; dst_addr = 16'h5000; word_count = 16'd3;
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      while (!mem_write && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      check("rst.write_seen", 64'(mem_write), 64'd1);
      #2 rst = 1'b1;
      #1 check_outputs_zero("rst_async");
      @(negedge clk);
      rst = 1'b0;
      obs_q.delete();
      exp_q.delete();
      run_vec(vecs[5], "after_rst");

`ifdef MEM_DMA_TIMEOUT_EN
      // Responder never answers: request drops after the limit, done with error.
      hold = 1'b1;
      latency = 0;
      obs_q.delete();
      @(negedge clk);
      start = 1'b1; src_addr = 16'h0100; dst_addr = 16'h0A00; word_count = 16'd1;
      @(negedge clk);
      start = 1'b0;
      cyc = 1;
      rd_cyc = 0;
      while (!done && cyc < 100) begin
         if (mem_read) rd_cyc++;
         @(negedge clk);
         cyc++;
      end
      check("tmo.read_cycles", 64'(rd_cyc), 64'd8);
      check("tmo.done", 64'(done), 64'd1);
      check("tmo.error", 64'(error), 64'd1);
      check("tmo.done_cycle", 64'(cyc), 64'd10);
      check("tmo.rd_dropped", 64'(mem_read), 64'd0);
      hold = 1'b0;
      @(negedge clk);
      check("tmo.error_pulse", 64'(error), 64'd0);
      check("tmo.no_txn", 64'(obs_q.size()), 64'd0);
`endif

      check("protocol", 64'(proto_err), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_dma_copy.md
Name: mem_dma_copy

Overview:
- Bus initiator for the 16-bit memory responder interface: read, write, byte_enable, address, wdata, resp, rdata.
- Copies a block of 16-bit words from a source region to a destination region, one word at a time.
- Each word is a read transaction followed by a write transaction.
- Sits between a control source (testbench or datapath control) and the memory model; it is the only master on the memory port.

Parameters:
- ADDR_W, 16, memory address width in bits.
- DATA_W, 16, memory data width; fixed at one word of 2 bytes.
- TIMEOUT_CYCLES, 1024, per-transaction response watchdog limit; used only with MEM_DMA_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a copy when idle.
- src_addr  in  16  source byte address; bit 0 ignored.
- dst_addr  in  16  destination byte address; bit 0 ignored.
- word_count  in  16  number of words to copy; 0 is legal.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle completion pulse.
- error  out  1  valid with done; 1 means the copy was aborted by timeout.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- mem_byte_enable  out  2  always 2'b11 during a write, 2'b00 otherwise.
- mem_address  out  16  word-aligned request address.
- mem_wdata  out  16  write data.
- mem_resp  in  1  one-cycle response from the memory.
- mem_rdata  in  16  read data, valid in the cycle mem_resp is high.

Behaviour:
- Reset values: busy, done, error, mem_read, mem_write = 0; mem_byte_enable = 2'b00; mem_address = 0; mem_wdata = 0.
- Reset is asynchronous: outputs clear immediately and any in-flight transaction is abandoned.
- All outputs are registered; no combinational path from any input to any output.
- Captured on start in IDLE: src and dst (bit 0 cleared), remaining = word_count.
- start is ignored while busy is high.
- States:
  - IDLE:
    - on start with word_count == 0 -> FINISH; no memory traffic.
    - on start otherwise -> READ.
  - READ:
    - mem_read = 1, mem_address = src; held stable until mem_resp.
    - on mem_resp: buffer <= mem_rdata, drop mem_read on that edge, -> WRITE.
  - WRITE:
    - mem_write = 1, mem_byte_enable = 2'b11, mem_address = dst, mem_wdata = buffer; held stable until mem_resp.
    - on mem_resp: drop mem_write; src += 2, dst += 2, remaining -= 1.
    - then -> FINISH if remaining was 1, else -> READ.
  - FINISH: done = 1 for exactly one cycle, busy = 0 -> IDLE.
- Request hold rule:
  - mem_read and mem_write are never high in the same cycle.
  - address, wdata and byte_enable never change while a request is high and mem_resp has not been seen.
- Back-to-back requests:
  - The next request may be asserted in the cycle after mem_resp.
  - The responder spends that cycle in its respond state, then samples the request in its idle state.
  - So the per-word cost is two full memory latencies plus at least 4 cycles.
- Addresses wrap modulo 2^16 (0xFFFE + 2 = 0x0000).
- Overlapping source and destination regions are copied in ascending order with no hazard protection.
- A mem_resp seen in IDLE or FINISH is ignored.

Optional Feature:
- Macro: MEM_DMA_TIMEOUT_EN.
- With the macro:
  - A cycle counter clears on entry to READ or WRITE and counts while the request is outstanding.
  - When it reaches TIMEOUT_CYCLES without mem_resp, the request is dropped and the block goes to FINISH with error = 1 alongside done.
  - remaining, src and dst keep their values at the abort point.
- Without the macro: no counter; error is tied 0; the block waits indefinitely for mem_resp.

Decomposition:
- Package mem_dma_pkg holds:
  - state enum (IDLE, READ, WRITE, FINISH);
  - WORD_BYTES = 2;
  - BE_FULL = 2'b11;
  - BE_NONE = 2'b00.
- Sub-module mem_dma_watchdog (counter, clear, expire flag), instantiated only under MEM_DMA_TIMEOUT_EN.
- All other logic lives in one module.

Test Plan:
- Single word:
  - Stimulus: preload mem[0x0100..0x0101] = 0xBEEF; start with src = 0x0100, dst = 0x0200, count = 1.
  - Required: one read then one write with be = 2'b11; memory at 0x0200 = 0xBEEF; done pulses once; error = 0.
- Multi-word:
  - Stimulus: src = 0x0010, dst = 0x0800, count = 4, source words 0x1111..0x4444.
  - Required: destination holds the same 4 words in order; exactly 8 transactions; busy high throughout.
- Zero count:
  - Stimulus: start with count = 0.
  - Required: done two cycles after start; mem_read and mem_write never assert.
- Odd address and wrap:
  - Stimulus: src = 0xFFFF, dst = 0x0003, count = 2.
  - Required: reads at 0xFFFE then 0x0000; writes at 0x0002 then 0x0004.
- Reset and ignored start:
  - Stimulus: assert rst while mem_write is high.
  - Required: all outputs 0 before the next edge; a following start works normally.
  - Stimulus: start while busy.
  - Required: no effect.
- Timeout (macro defined, TIMEOUT_CYCLES = 8):
  - Stimulus: responder held so mem_resp never asserts.
  - Required: mem_read drops after 8 cycles; done = 1 and error = 1 in the same cycle.
